get_certificate_request: RTL and testbench
==========================================

GET_CERTIFICATE_REQUEST -- requirements
Module: get_certificate_request

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1000, the number of cycles to wait for a response before one retry attempt.
REQ-002 The module SHALL have parameter RETRY_LIMIT, default 2, the number of retries allowed per offset after a timeout.
REQ-003 The module SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 Port reset_n: input, 1 bit, synchronous active-low reset.
REQ-006 Port Start: input, 1 bit, begins a chain fetch; sampled only in IDLE.
REQ-007 Port Slot: input, `SIZE_OF_HEADER_VARS bits, the slot to fetch; captured at Start.
REQ-008 Port Req_valid: output, 1 bit, a request message is presented.
REQ-009 Port Req_ack: input, 1 bit, the responder accepted Req_msg.
REQ-010 Port Req_msg: output, `MSG_LEN bits, the request message: header, offset, length, then zeros.
REQ-011 Port Resp_valid: input, 1 bit, Resp_msg and Resp_error are valid this cycle.
REQ-012 Port Resp_msg: input, `MSG_LEN bits, the response message: a 32-bit header, then a 2056-bit payload.
REQ-013 Port Resp_error: input, 1 bit, the responder flagged an invalid request.
REQ-014 Port Cert_valid: output, 1 bit, a one-cycle pulse; Cert_data and Cert_index are valid.
REQ-015 Port Cert_data: output, 2056 bits, the certificate payload received.
REQ-016 Port Cert_index: output, 4 bits, the offset of Cert_data.
REQ-017 Port Done: output, 1 bit, a one-cycle pulse when the whole chain has been received.
REQ-018 Port Error: output, 1 bit, a one-cycle pulse when the fetch aborts.
REQ-019 Port Error_code: output, 3 bits, the abort cause; held until the next accepted Start.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, SEND, WAIT, NEXT, FINISH, FAIL.
REQ-021 In IDLE with Start=1, the FSM SHALL capture Slot, clear offset, retries and Error_code, and go to SEND; if Slot>2, it SHALL instead go to FAIL with code 3'b001.
REQ-022 The chain length per slot SHALL be: slot0 6, slot1 4, slot2 5 offsets.
REQ-023 Req_msg[`MSG_LEN-1 -: 32] SHALL be {`PROTOCOL_VERSION, `GET_CERTIFICATE_CMD, slot, 8'h00}; the next 16 bits SHALL be the offset; the next 16 bits SHALL be the package length for (slot, offset); all remaining bits SHALL be 0.
REQ-024 In SEND, Req_valid SHALL be 1 and Req_msg SHALL be stable until Req_ack; on Req_ack the FSM SHALL go to WAIT and clear the timeout counter. Req_valid SHALL be 0 in every other state.
REQ-025 In WAIT, the timeout counter SHALL increment each cycle without Resp_valid.
REQ-026 A Resp_valid arriving in the same cycle the counter reaches TIMEOUT_CYCLES-1 SHALL take priority over the timeout.
REQ-027 On timeout with retries<RETRY_LIMIT, the FSM SHALL increment retries and return to SEND with the same offset.
REQ-028 On timeout with retries at RETRY_LIMIT, the FSM SHALL go to FAIL with code 3'b100.
REQ-029 On Resp_valid with Resp_error=1, the FSM SHALL go to FAIL with code 3'b010; Resp_error SHALL take precedence over the header check.
REQ-030 On Resp_valid with a header byte1 not equal to `CERTIFICATE_ANSWER_CMD, or byte2 not equal to slot, the FSM SHALL go to FAIL with code 3'b011.
REQ-031 On Resp_valid with a good header, the next cycle SHALL pulse Cert_valid with Cert_data = Resp_msg[2055:0] and Cert_index = offset, and the FSM SHALL go to NEXT.
REQ-032 In NEXT, the FSM SHALL reset retries to 0; if offset = chain length-1 it SHALL go to FINISH, else it SHALL increment offset and go to SEND.
REQ-033 FINISH SHALL pulse Done for one cycle, then go to IDLE.
REQ-034 FAIL SHALL pulse Error for one cycle, then go to IDLE.
REQ-035 Resp_valid seen outside WAIT SHALL be ignored.
REQ-036 Start seen outside IDLE SHALL be ignored.
REQ-037 The offset counter SHALL never wrap, because it is bounded by the chain length.

Reset
REQ-038 On reset_n=0 at a clock edge, the FSM SHALL go to IDLE, and the offset, retries, timeout counter, all outputs and Error_code SHALL become 0, including mid-transaction.
REQ-039 The cycle after reset_n returns to 1, the module SHALL accept Start.

Structure
REQ-040 The shared package SHALL hold the FSM state encoding, the error codes, the per-slot chain lengths, and the length lookup built from `SLOTn_CERTm_LENGTH.
REQ-041 `MSG_LEN, the header macros and the command codes SHALL remain shared defines.
REQ-042 A sub-module cert_req_timer (a loadable counter with a timeout flag) SHALL be instantiated once.

Verification
REQ-043 Slot=0 with a responder echoing good answers SHALL produce 6 Cert_valid pulses with Cert_index 0..5, then Done; Error SHALL stay 0.
REQ-044 Slot=3 SHALL produce an Error pulse 1 cycle after Start with Error_code=3'b001 and no Req_valid.
REQ-045 Slot=1 with Resp_error=1 on offset 2 SHALL give 2 Cert_valid pulses, then Error with code 3'b010.
REQ-046 Slot=2 with the responder silent on offset 1 and TIMEOUT_CYCLES=8 SHALL give 3 Req_valid assertions for offset 1, then Error with code 3'b100.
REQ-047 Slot=0 with a response header cmd byte corrupted to 8'h00 SHALL give code 3'b011.
REQ-048 reset_n=0 asserted during WAIT of offset 3 SHALL return all outputs to 0 next cycle, and a fresh Start SHALL restart at offset 0.

Source files
------------

// File: rtl/get_certificate_request_pkg.sv
// Shared message defines plus the FSM encoding, abort codes, chain lengths and
// per-certificate length lookup used by the certificate chain fetcher.
`ifndef GET_CERT_REQ_DEFS
`define GET_CERT_REQ_DEFS
`define SIZE_OF_HEADER_VARS 8
`define MSG_LEN 2088
`define PROTOCOL_VERSION 8'h10
`define GET_CERTIFICATE_CMD 8'h82
`define CERTIFICATE_ANSWER_CMD 8'h02
`define SLOT0_CERT0_LENGTH 16'h0200
`define SLOT0_CERT1_LENGTH 16'h0211
`define SLOT0_CERT2_LENGTH 16'h0222
`define SLOT0_CERT3_LENGTH 16'h0233
`define SLOT0_CERT4_LENGTH 16'h0244
`define SLOT0_CERT5_LENGTH 16'h0255
`define SLOT1_CERT0_LENGTH 16'h0300
`define SLOT1_CERT1_LENGTH 16'h0311
`define SLOT1_CERT2_LENGTH 16'h0322
`define SLOT1_CERT3_LENGTH 16'h0333
`define SLOT2_CERT0_LENGTH 16'h0400
`define SLOT2_CERT1_LENGTH 16'h0411
`define SLOT2_CERT2_LENGTH 16'h0422
`define SLOT2_CERT3_LENGTH 16'h0433
`define SLOT2_CERT4_LENGTH 16'h0444
`endif

package get_certificate_request_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT, NEXT, FINISH, FAIL} state_t;
    typedef logic [`SIZE_OF_HEADER_VARS-1:0] slot_t;

    localparam int CERT_W = 2056;
    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_SLOT = 3'b001;
    localparam logic [2:0] ERR_RESP = 3'b010;
    localparam logic [2:0] ERR_HDR  = 3'b011;
    localparam logic [2:0] ERR_TMO  = 3'b100;

    localparam slot_t SLOT0    = slot_t'(0);
    localparam slot_t SLOT1    = slot_t'(1);
    localparam slot_t SLOT2    = slot_t'(2);
    localparam slot_t MAX_SLOT = slot_t'(2);

    localparam logic [3:0] SLOT0_CHAIN = 4'd6;
    localparam logic [3:0] SLOT1_CHAIN = 4'd4;
    localparam logic [3:0] SLOT2_CHAIN = 4'd5;

    function automatic logic [3:0] chain_len(input slot_t slot);
        case (slot)
            SLOT0:   return SLOT0_CHAIN;
            SLOT1:   return SLOT1_CHAIN;
            SLOT2:   return SLOT2_CHAIN;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] pkg_len(input slot_t slot, input logic [3:0] off);
        logic [15:0] len;
        len = 16'h0000;
        case (slot)
            SLOT0: case (off)
                4'd0: len = `SLOT0_CERT0_LENGTH;
                4'd1: len = `SLOT0_CERT1_LENGTH;
                4'd2: len = `SLOT0_CERT2_LENGTH;
                4'd3: len = `SLOT0_CERT3_LENGTH;
                4'd4: len = `SLOT0_CERT4_LENGTH;
                4'd5: len = `SLOT0_CERT5_LENGTH;
                default: len = 16'h0000;
            endcase
            SLOT1: case (off)
                4'd0: len = `SLOT1_CERT0_LENGTH;
                4'd1: len = `SLOT1_CERT1_LENGTH;
                4'd2: len = `SLOT1_CERT2_LENGTH;
                4'd3: len = `SLOT1_CERT3_LENGTH;
                default: len = 16'h0000;
            endcase
            SLOT2: case (off)
                4'd0: len = `SLOT2_CERT0_LENGTH;
                4'd1: len = `SLOT2_CERT1_LENGTH;
                4'd2: len = `SLOT2_CERT2_LENGTH;
                4'd3: len = `SLOT2_CERT3_LENGTH;
                4'd4: len = `SLOT2_CERT4_LENGTH;
                default: len = 16'h0000;
            endcase
            default: len = 16'h0000;
        endcase
        return len;
    endfunction
endpackage

// File: rtl/get_certificate_request_if.sv
// Control, request/response and certificate delivery signals of the chain fetcher.
// slave = fetcher side, master = host/responder side.
interface get_certificate_request_if;
    logic                            Start;
    logic [`SIZE_OF_HEADER_VARS-1:0] Slot;
    logic                            Req_valid;
    logic                            Req_ack;
    logic [`MSG_LEN-1:0]             Req_msg;
    logic                            Resp_valid;
    logic [`MSG_LEN-1:0]             Resp_msg;
    logic                            Resp_error;
    logic                            Cert_valid;
    logic [2055:0]                   Cert_data;
    logic [3:0]                      Cert_index;
    logic                            Done;
    logic                            Error;
    logic [2:0]                      Error_code;

    modport slave (
        input  Start, Slot, Req_ack, Resp_valid, Resp_msg, Resp_error,
        output Req_valid, Req_msg, Cert_valid, Cert_data, Cert_index, Done, Error, Error_code
    );
    modport master (
        output Start, Slot, Req_ack, Resp_valid, Resp_msg, Resp_error,
        input  Req_valid, Req_msg, Cert_valid, Cert_data, Cert_index, Done, Error, Error_code
    );
endinterface

// File: rtl/get_certificate_request_timer.sv
// Response timeout counter: cleared by i_load, counts while i_en, and saturates
// with o_timeout high once LIMIT-1 is reached.
module cert_req_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_timeout
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !o_timeout) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == LAST);
endmodule

// File: rtl/get_certificate_request.sv
// Fetches a certificate chain one offset at a time with per-offset timeout/retry.
// Req_msg held until Req_ack; Cert_valid pulses one cycle after a good response.
module get_certificate_request
    import get_certificate_request_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RETRY_LIMIT    = 2
) (
    input logic                     clk,
    input logic                     reset_n,
    get_certificate_request_if.slave bus
);
    localparam int RW = $clog2(RETRY_LIMIT + 2);
    localparam logic [RW-1:0] RLIM = RW'(RETRY_LIMIT);

    state_t              r_state, w_next;
    slot_t               r_slot;
    logic [3:0]          r_offset;
    logic [RW-1:0]       r_retries;
    logic [2:0]          r_err_code;
    logic                r_cert_vld;
    logic [CERT_W-1:0]   r_cert_dat;
    logic [3:0]          r_cert_idx;

    logic                w_capture, w_set_err, w_cert, w_retry, w_clr_retry, w_inc_off;
    logic                w_tmr_load, w_tmr_en, w_timeout, w_hdr_bad;
    logic [2:0]          w_err;
    logic [`MSG_LEN-1:0] w_req_msg;
    logic                w_unused_hdr;

    cert_req_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_tmr_load),
        .i_en      (w_tmr_en),
        .o_timeout (w_timeout)
    );

    // Only the command and slot bytes of the answer header are checked.
    assign w_hdr_bad = (bus.Resp_msg[`MSG_LEN-9 -: 8] != `CERTIFICATE_ANSWER_CMD) ||
                       (bus.Resp_msg[`MSG_LEN-17 -: 8] != r_slot);
    assign w_unused_hdr = ^{bus.Resp_msg[`MSG_LEN-1 -: 8], bus.Resp_msg[`MSG_LEN-25 -: 8]};
    assign w_tmr_en  = (r_state == WAIT) && !bus.Resp_valid;
    assign w_req_msg = {`PROTOCOL_VERSION, `GET_CERTIFICATE_CMD, r_slot, 8'h00,
                        12'h000, r_offset, pkg_len(r_slot, r_offset),
                        {(`MSG_LEN-64){1'b0}}};

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_set_err   = 1'b0;
        w_err       = ERR_NONE;
        w_cert      = 1'b0;
        w_retry     = 1'b0;
        w_clr_retry = 1'b0;
        w_inc_off   = 1'b0;
        w_tmr_load  = 1'b0;
        case (r_state)
            IDLE: if (bus.Start) begin
                w_capture = 1'b1;
                if (bus.Slot > MAX_SLOT) begin
                    w_next = FAIL; w_set_err = 1'b1; w_err = ERR_SLOT;
                end else begin
                    w_next = SEND;
                end
            end
            SEND: if (bus.Req_ack) begin
                w_next = WAIT; w_tmr_load = 1'b1;
            end
            // A response in the timeout cycle wins over the timeout.
            WAIT: if (bus.Resp_valid) begin
                if (bus.Resp_error) begin
                    w_next = FAIL; w_set_err = 1'b1; w_err = ERR_RESP;
                end else if (w_hdr_bad) begin
                    w_next = FAIL; w_set_err = 1'b1; w_err = ERR_HDR;
                end else begin
                    w_next = NEXT; w_cert = 1'b1;
                end
            end else if (w_timeout) begin
                if (r_retries < RLIM) begin
                    w_next = SEND; w_retry = 1'b1;
                end else begin
                    w_next = FAIL; w_set_err = 1'b1; w_err = ERR_TMO;
                end
            end
            NEXT: begin
                w_clr_retry = 1'b1;
                if (r_offset == chain_len(r_slot) - 4'd1) w_next = FINISH;
                else begin
                    w_next = SEND; w_inc_off = 1'b1;
                end
            end
            FINISH:  w_next = IDLE;
            FAIL:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot     <= '0;
            r_offset   <= '0;
            r_retries  <= '0;
            r_err_code <= ERR_NONE;
            r_cert_vld <= 1'b0;
            r_cert_dat <= '0;
            r_cert_idx <= '0;
        end else begin
            r_cert_vld <= w_cert;
            if (w_capture) begin
                r_slot     <= bus.Slot;
                r_offset   <= '0;
                r_retries  <= '0;
                r_err_code <= ERR_NONE;
            end
            if (w_set_err)   r_err_code <= w_err;
            if (w_retry)     r_retries  <= r_retries + 1'b1;
            if (w_clr_retry) r_retries  <= '0;
            if (w_inc_off)   r_offset   <= r_offset + 4'd1;
            if (w_cert) begin
                r_cert_dat <= bus.Resp_msg[CERT_W-1:0];
                r_cert_idx <= r_offset;
            end
        end
    end

    assign bus.Req_valid  = (r_state == SEND);
    assign bus.Req_msg    = (r_state == SEND) ? w_req_msg : '0;
    assign bus.Cert_valid = r_cert_vld;
    assign bus.Cert_data  = r_cert_dat;
    assign bus.Cert_index = r_cert_idx;
    assign bus.Done       = (r_state == FINISH);
    assign bus.Error      = (r_state == FAIL);
    assign bus.Error_code = r_err_code;
endmodule

// File: tb/tb_get_certificate_request.sv
// Scoreboard bench: directed fetches push expected requests/outputs; monitors
// pop and compare on each new Req_valid and each Cert_valid/Done/Error pulse.
module tb_get_certificate_request;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    get_certificate_request_if bus();

    get_certificate_request #(.TIMEOUT_CYCLES(8), .RETRY_LIMIT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {int kind; int slot; int idx; logic [2:0] code;} exp_t; // kind 0 cert,1 done,2 error
    typedef struct {int slot; int off;} req_t;

    exp_t out_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_slot, resp_delay, silent_off, err_off, bad_cmd_off;

    function automatic logic [15:0] exp_len(int s, int o);
        return 16'(32'h0200 + s * 32'h100 + o * 32'h11);
    endfunction

    function automatic logic [2055:0] payload(int s, int o);
        logic [7:0] b;
        b = {s[3:0], o[3:0]};
        return {257{b}};
    endfunction

    function automatic logic [`MSG_LEN-1:0] exp_req(int s, int o);
        return {8'h10, 8'h82, 8'(s), 8'h00, 16'(o), exp_len(s, o), {(`MSG_LEN-64){1'b0}}};
    endfunction

    task automatic cfg(int s, int d, int sil, int er, int bc);
        cur_slot = s; resp_delay = d; silent_off = sil; err_off = er; bad_cmd_off = bc;
    endtask

    task automatic exp_out(int k, int s, int i, logic [2:0] c);
        exp_t e2;
        e2.kind = k; e2.slot = s; e2.idx = i; e2.code = c;
        out_q.push_back(e2);
    endtask

    task automatic exp_rq(int s, int o);
        req_t r2;
        r2.slot = s; r2.off = o;
        req_q.push_back(r2);
    endtask

    // Responder: acks each request, then answers after resp_delay cycles.
    initial begin
        bus.Req_ack = 1'b0; bus.Resp_valid = 1'b0; bus.Resp_error = 1'b0; bus.Resp_msg = '0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.Req_valid) begin
                int off;
                off = int'(bus.Req_msg[`MSG_LEN-33 -: 16]);
                bus.Req_ack = 1'b1;
                @(negedge clk);
                bus.Req_ack = 1'b0;
                if (off != silent_off) begin
                    repeat (resp_delay) @(negedge clk);
                    bus.Resp_msg   = {8'h10, (off == bad_cmd_off) ? 8'h00 : 8'h02, 8'(cur_slot), 8'h00,
                                      payload(cur_slot, off)};
                    bus.Resp_error = (off == err_off);
                    bus.Resp_valid = 1'b1;
                    @(negedge clk);
                    bus.Resp_valid = 1'b0;
                    bus.Resp_error = 1'b0;
                end
            end
        end
    end

    // Request monitor
    logic prev_req = 1'b0;
    req_t rq;
    always @(negedge clk) begin
        if (reset_n && bus.Req_valid && !prev_req) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got offset %0d, no request expected",
                         bus.Req_msg[`MSG_LEN-33 -: 16]);
            end else begin
                rq = req_q.pop_front();
                if (bus.Req_msg !== exp_req(rq.slot, rq.off)) begin
                    errors++;
                    $display("FAIL req_msg: got hdr %h off %0d len %h, expected slot %0d off %0d len %h",
                             bus.Req_msg[`MSG_LEN-1 -: 32], bus.Req_msg[`MSG_LEN-33 -: 16],
                             bus.Req_msg[`MSG_LEN-49 -: 16], rq.slot, rq.off, exp_len(rq.slot, rq.off));
                end
            end
        end
        prev_req = reset_n && bus.Req_valid;
    end

    // Output monitor
    exp_t e;
    int   kind;
    bit   ok;
    always @(negedge clk) begin
        if (reset_n && (bus.Cert_valid || bus.Done || bus.Error)) begin
            kind = bus.Cert_valid ? 0 : (bus.Done ? 1 : 2);
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got kind %0d idx %0d code %b, nothing expected",
                         kind, bus.Cert_index, bus.Error_code);
            end else begin
                e  = out_q.pop_front();
                ok = (kind == e.kind);
                if (kind == 0) ok = ok && (bus.Cert_index == 4'(e.idx)) && (bus.Cert_data == payload(e.slot, e.idx));
                if (kind == 2) ok = ok && (bus.Error_code == e.code);
                if (!ok) begin
                    errors++;
                    $display("FAIL out_event: got kind %0d idx %0d code %b data_ok %0d, expected kind %0d idx %0d code %b",
                             kind, bus.Cert_index, bus.Error_code, bus.Cert_data == payload(e.slot, e.idx),
                             e.kind, e.idx, e.code);
                end
            end
        end
    end

    task automatic start_fetch(int s);
        @(negedge clk);
        bus.Slot  = 8'(s);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        checks++;
        if (bus.Error_code !== ((s > 2) ? 3'b001 : 3'b000)) begin
            errors++;
            $display("FAIL start_err_code: got %b, expected %b", bus.Error_code, (s > 2) ? 3'b001 : 3'b000);
        end
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((out_q.size() != 0 || req_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (out_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs and %0d requests pending, expected 0",
                     name, out_q.size(), req_q.size());
            out_q.delete();
            req_q.delete();
        end
    endtask

    task automatic check_zero(string name);
        checks++;
        if ({bus.Req_valid, bus.Cert_valid, bus.Done, bus.Error} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_strobes: got req/cert/done/err %b, expected 0000", name,
                     {bus.Req_valid, bus.Cert_valid, bus.Done, bus.Error});
        end
        checks++;
        if (bus.Error_code !== 3'b000 || bus.Cert_index !== 4'd0) begin
            errors++;
            $display("FAIL %s_code_idx: got code %b idx %0d, expected 0 0", name, bus.Error_code, bus.Cert_index);
        end
        checks++;
        if (bus.Cert_data !== '0 || bus.Req_msg !== '0) begin
            errors++;
            $display("FAIL %s_buses: cert_data zero %0d req_msg zero %0d, expected 1 1", name,
                     bus.Cert_data == '0, bus.Req_msg == '0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; bus.Start = 1'b0; bus.Slot = '0;
        cfg(0, 2, -1, -1, -1);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Full slot 0 chain
        for (int o = 0; o < 6; o++) begin exp_rq(0, o); exp_out(0, 0, o, 3'b000); end
        exp_out(1, 0, 0, 3'b000);
        start_fetch(0);
        drain("slot0");

        // Out-of-range slot aborts immediately with no request
        cfg(3, 2, -1, -1, -1);
        exp_out(2, 3, 0, 3'b001);
        start_fetch(3);
        checks++;
        if (bus.Error !== 1'b1 || bus.Req_valid !== 1'b0) begin
            errors++;
            $display("FAIL slot3_timing: got Error %b Req_valid %b, expected 1 0", bus.Error, bus.Req_valid);
        end
        drain("slot3");

        // Responder error on offset 2; a second Start mid-run is ignored
        cfg(1, 2, -1, 2, -1);
        for (int o = 0; o < 3; o++) exp_rq(1, o);
        exp_out(0, 1, 0, 3'b000); exp_out(0, 1, 1, 3'b000); exp_out(2, 1, 0, 3'b010);
        start_fetch(1);
        repeat (3) @(negedge clk);
        bus.Slot = 8'd0; bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        drain("slot1_resp_err");
        checks++;
        if (bus.Error_code !== 3'b010) begin
            errors++;
            $display("FAIL err_code_hold: got %b, expected 010", bus.Error_code);
        end

        // Silent responder on offset 1: initial try plus two retries, then timeout abort
        cfg(2, 2, 1, -1, -1);
        exp_rq(2, 0); exp_rq(2, 1); exp_rq(2, 1); exp_rq(2, 1);
        exp_out(0, 2, 0, 3'b000); exp_out(2, 2, 0, 3'b100);
        start_fetch(2);
        drain("slot2_timeout");

        // Corrupted answer command byte on offset 2
        cfg(0, 2, -1, -1, 2);
        for (int o = 0; o < 3; o++) exp_rq(0, o);
        exp_out(0, 0, 0, 3'b000); exp_out(0, 0, 1, 3'b000); exp_out(2, 0, 0, 3'b011);
        start_fetch(0);
        drain("slot0_bad_hdr");

        // Responses land exactly in the last WAIT cycle: response must win
        cfg(1, 7, -1, -1, -1);
        for (int o = 0; o < 4; o++) begin exp_rq(1, o); exp_out(0, 1, o, 3'b000); end
        exp_out(1, 1, 0, 3'b000);
        start_fetch(1);
        drain("slot1_edge");

        // Reset while waiting on offset 3, then a fresh fetch restarts at offset 0
        cfg(0, 2, 3, -1, -1);
        for (int o = 0; o < 4; o++) exp_rq(0, o);
        for (int o = 0; o < 3; o++) exp_out(0, 0, o, 3'b000);
        start_fetch(0);
        for (int n = 0; n < 500 && (out_q.size() != 0 || req_q.size() != 0); n++) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        reset_n = 1'b1;
        out_q.delete();
        req_q.delete();
        cfg(0, 2, -1, -1, -1);
        for (int o = 0; o < 6; o++) begin exp_rq(0, o); exp_out(0, 0, o, 3'b000); end
        exp_out(1, 0, 0, 3'b000);
        start_fetch(0);
        drain("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
